// File: rtl/data_memory_line_responder.sv
// Memory-side responder for L1 data-cache line fills and word write-through.
// Holds a 2^ADDR_WIDTH-word array organised as 128-bit lines, serves one
// request at a time and returns the addressed line after LATENCY cycles.
module data_memory_line_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [31:0]  req_address,
  input  logic [31:0]  req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [127:0] resp_line,
  output logic         resp_write_ack,
  output logic         busy
);

  localparam int LINE_BITS = ADDR_WIDTH - 2;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [3:0]           cnt_r;
  logic [LINE_BITS-1:0] line_idx_r;
  logic [1:0]           word_sel_r;
  logic                 wr_r;
  logic [31:0]          wdata_r;
  logic                 resp_valid_r;
  logic [127:0]         resp_line_r;
  logic                 resp_write_ack_r;
  logic [31:0]          mem_r [0:DEPTH-1];

  logic                 accept_s;
  logic                 done_s;
  logic [127:0]         line_s;
  logic                 unused_addr_s;

  // Byte-offset and alias bits of the address are intentionally not decoded.
  assign unused_addr_s = ^{req_address[31:ADDR_WIDTH+2], req_address[1:0]};

  // Handshake and countdown-expiry strobes shared by FSM and datapath.
  always_comb begin
    accept_s = req_valid && (state_r == ST_IDLE);
    done_s   = (state_r == ST_BUSY) && (cnt_r == 4'd0);
  end

  // State register; reset forces IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: accept -> countdown -> hold response until taken.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State-decoded and registered outputs; nothing flows from inputs directly.
  always_comb begin
    req_ready      = (state_r == ST_IDLE);
    busy           = (state_r != ST_IDLE);
    resp_valid     = resp_valid_r;
    resp_line      = resp_line_r;
    resp_write_ack = resp_write_ack_r;
  end

  // Line assembly with the pending write merged in (write-then-read result).
  always_comb begin
    line_s = 128'd0;
    for (int i = 0; i < 4; i++) begin
      if (wr_r && (word_sel_r == 2'(i))) begin
        line_s[i*32 +: 32] = wdata_r;
      end else begin
        line_s[i*32 +: 32] = mem_r[{line_idx_r, 2'(i)}];
      end
    end
  end

  // Request latch, latency counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r            <= 4'd0;
      line_idx_r       <= '0;
      word_sel_r       <= 2'd0;
      wr_r             <= 1'b0;
      wdata_r          <= 32'd0;
      resp_valid_r     <= 1'b0;
      resp_line_r      <= 128'd0;
      resp_write_ack_r <= 1'b0;
    end else begin
      if (accept_s) begin
        line_idx_r <= req_address[ADDR_WIDTH+1:4];
        word_sel_r <= req_address[3:2];
        wr_r       <= req_write;
        wdata_r    <= req_wdata;
        cnt_r      <= 4'(LATENCY - 1);
      end
      if ((state_r == ST_BUSY) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (done_s) begin
        resp_line_r      <= line_s;
        resp_write_ack_r <= wr_r;
        resp_valid_r     <= 1'b1;
      end
      if ((state_r == ST_RESP) && resp_ready) begin
        resp_valid_r <= 1'b0;
      end
    end
  end

  // Array write commits on the countdown-expiry edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (done_s && wr_r) begin
      mem_r[{line_idx_r, word_sel_r}] <= wdata_r;
    end
  end

endmodule
